rr_req_gnt_arb: RTL
===================

RR_REQ_GNT_ARB -- requirements
Module: rr_req_gnt_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of requester channels, legal range 2..16.
REQ-002 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles per owner while others wait, legal range 1..255.
REQ-003 Derived widths SHALL be ID_W = max(1, clog2(N_REQ)) and CNT_W = clog2(MAX_HOLD+1).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  N_REQ  per-channel request, level-sensitive, bit i = channel i.
REQ-007 gnt  output  N_REQ  registered grant vector, one-hot or all-zero.
REQ-008 gnt_vld  output  1  registered; high when any gnt bit is high.
REQ-009 gnt_id  output  ID_W  registered index of the current owner; holds last owner when gnt_vld low.
REQ-010 expire  output  1  registered one-cycle pulse marking a forced hand-over by hold timeout.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE (no owner) and GRANT (one owner).
REQ-012 IDLE: at any rising edge where req != 0, the FSM SHALL enter GRANT with the winner's gnt bit set; latency is one edge from req sampled high to gnt high.
REQ-013 The winner SHALL be the first set req bit at or after pointer ptr, searching upward and wrapping from N_REQ-1 to 0.
REQ-014 On every new grant, ptr SHALL load (winner+1) mod N_REQ, and hold counter cnt SHALL load 1.
REQ-015 GRANT, owner req sampled high, cnt < MAX_HOLD: the grant SHALL hold and cnt SHALL increment.
REQ-016 GRANT, owner req sampled low: at that edge gnt SHALL move directly to the next winner among the remaining requests, with no idle cycle; if none remain, the FSM SHALL return to IDLE with gnt = 0.
REQ-017 GRANT, owner req high, cnt == MAX_HOLD, another req pending: at that edge gnt SHALL move to the next winner excluding the owner, and expire SHALL be high for exactly that one cycle.
REQ-018 GRANT, owner req high, cnt == MAX_HOLD, no other req pending: the grant SHALL hold, cnt SHALL reload 1, and expire SHALL stay low.
REQ-019 cnt SHALL never exceed MAX_HOLD and SHALL be CNT_W bits wide, with no overflow.
REQ-020 Requests arriving while another channel owns the grant SHALL wait; no grant SHALL be revoked except by REQ-016 or REQ-017.
REQ-021 gnt SHALL never have more than one bit set, and gnt_vld SHALL equal |gnt in every cycle.
REQ-022 With MAX_HOLD = 1 and all channels requesting, the grant SHALL rotate every cycle and expire SHALL be high every cycle.

Reset
REQ-023 While rst_n is low, all of the following SHALL hold immediately, without waiting for a clock edge: gnt = 0, gnt_vld = 0, gnt_id = 0, expire = 0, ptr = 0, cnt = 0, FSM = IDLE.
REQ-024 After rst_n deasserts, the earliest grant SHALL occur at the first rising edge that samples rst_n high and req != 0.
REQ-025 Reset asserted mid-grant SHALL discard ownership and hold count, and SHALL return ptr to 0.

Verification (N_REQ = 4, MAX_HOLD = 4)
REQ-026 Single request: req = 0001 for 3 cycles, then 0000 -> gnt = 0001 and gnt_id = 0 for 3 cycles starting one edge after req rises; gnt = 0000 at the edge sampling req low.
REQ-027 Priority and hand-over: after reset, req = 1010 held -> gnt = 0010 first (ptr = 0); drop req[1] -> gnt = 1000 at the next edge with no gap; drop req[3] -> IDLE.
REQ-028 Timeout: req = 0011 held constantly -> ch0 granted 4 cycles, then gnt = 0010 with expire = 1 for one cycle, ch1 granted 4 cycles, then back to ch0 with expire = 1.
REQ-029 Lone holder: req = 0100 held for 10 cycles -> gnt = 0100 throughout and expire never asserts.
REQ-030 Wrap: ch3 owns, then req = 1001 and ch3 drops -> gnt = 0001 and ptr = 1.
REQ-031 Async reset: rst_n pulled low between edges while gnt = 0010 -> all outputs 0 before the next edge; once released with req = 0010, gnt = 0010 one edge later.

Source files
------------

// File: rtl/rr_req_gnt_arb_if.sv
// ---------------------------------------------------------------------------
// rr_req_gnt_arb_if
//
// Purpose : Groups the request/grant signals of the round-robin arbiter.
//           Requesters drive req. The arbiter returns a registered grant
//           vector, the owner index and a hold-timeout pulse.
//
// Parameters
//   N_REQ   : number of requester channels (2..16)
//
// Signals
//   req     : per-channel level request, bit i = channel i
//   gnt     : one-hot (or all-zero) grant vector
//   gnt_vld : high while any gnt bit is high
//   gnt_id  : index of the current owner; keeps the last owner when idle
//   expire  : one-cycle pulse on a forced hand-over by hold timeout
//
// Modports
//   master  : requester side (drives req)
//   slave   : arbiter side (drives the grant outputs)
// ---------------------------------------------------------------------------
interface rr_req_gnt_arb_if #(
  parameter int N_REQ = 4
);

  localparam int ID_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             gnt_vld;
  logic [ID_W-1:0]  gnt_id;
  logic             expire;

  modport master (
    output req,
    input  gnt,
    input  gnt_vld,
    input  gnt_id,
    input  expire
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_vld,
    output gnt_id,
    output expire
  );

endinterface

// File: rtl/rr_req_gnt_arb.sv
// ---------------------------------------------------------------------------
// rr_req_gnt_arb
//
// Purpose : Round-robin request/grant arbiter with a bounded hold time.
//           A channel keeps the grant while its request stays high. After
//           MAX_HOLD consecutive cycles it is forced to hand over, but only
//           if another channel is waiting. The hand-over is flagged with a
//           one-cycle expire pulse. All outputs are registered.
//
// Parameters
//   N_REQ    : number of requester channels (2..16)
//   MAX_HOLD : maximum consecutive grant cycles while others wait (1..255)
//
// Ports
//   clk      : single clock, rising-edge
//   rst_n    : asynchronous active-low reset
//   bus      : rr_req_gnt_arb_if.slave
//              (req in; gnt, gnt_vld, gnt_id and expire out)
// ---------------------------------------------------------------------------
module rr_req_gnt_arb #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_req_gnt_arb_if.slave bus
);

  localparam int ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [ID_W-1:0]  ID_LAST = ID_W'(N_REQ - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t           state_q,   state_d;
  logic [N_REQ-1:0] gnt_q,     gnt_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic [ID_W-1:0]  gnt_id_q,  gnt_id_d;
  logic [ID_W-1:0]  ptr_q,     ptr_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             expire_q,  expire_d;

  // -------------------------------------------------------------------------
  // Winner search
  //
  // Returns the first set bit of mask at or after start, wrapping from
  // N_REQ-1 back to 0. The loop runs from the farthest offset down to the
  // nearest, so the last match it records is the nearest one. This needs no
  // early exit. When mask is zero the result is don't-care; callers gate it
  // with |mask.
  // -------------------------------------------------------------------------
  function automatic logic [ID_W-1:0] rr_pick(
    input logic [N_REQ-1:0] mask,
    input logic [ID_W-1:0]  start
  );
    logic [ID_W-1:0]  win;
    logic [N_REQ-1:0] shifted;
    int               idx;
    win = start;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      idx = int'(start) + off;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      shifted = mask >> idx;
      if (shifted[0]) begin
        win = ID_W'(idx);
      end
    end
    return win;
  endfunction

  // -------------------------------------------------------------------------
  // Candidate selection
  //
  // While the owner still requests, the only way to move the grant is a
  // timeout. In that case the owner is masked out of the search. In every
  // other situation the owner's request bit is low or there is no owner,
  // so the raw request vector is the candidate set.
  // -------------------------------------------------------------------------
  logic             owner_req;
  logic [N_REQ-1:0] others_req;
  logic [N_REQ-1:0] pick_mask;
  logic             pick_any;
  logic [ID_W-1:0]  pick_id;
  logic [N_REQ-1:0] pick_oh;
  logic [ID_W-1:0]  pick_ptr;

  assign owner_req  = (state_q == ST_GRANT) && |(bus.req & gnt_q);
  assign others_req = bus.req & ~gnt_q;
  assign pick_mask  = owner_req ? others_req : bus.req;
  assign pick_any   = |pick_mask;
  assign pick_id    = rr_pick(pick_mask, ptr_q);

  // The pointer moves to the channel just above the new winner.
  assign pick_ptr   = (pick_id == ID_LAST) ? '0 : pick_id + ID_W'(1);

  // Decode the winner index into its one-hot grant vector.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pick_dec
      assign pick_oh[gi] = (pick_id == ID_W'(gi));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  logic take_grant;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    expire_d   = 1'b0;
    take_grant = 1'b0;

    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        cnt_d = '0;
        if (pick_any) begin
          take_grant = 1'b1;
        end
      end

      ST_GRANT: begin
        if (owner_req) begin
          if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end else if (pick_any) begin
            // Hold budget used up and someone else is waiting.
            take_grant = 1'b1;
            expire_d   = 1'b1;
          end else begin
            // Nobody is waiting, so the owner keeps the grant and starts a
            // fresh hold window. This keeps cnt from ever passing MAX_HOLD.
            cnt_d = CNT_ONE;
          end
        end else if (pick_any) begin
          // Owner released; hand over in the same edge with no idle gap.
          take_grant = 1'b1;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase

    if (take_grant) begin
      state_d  = ST_GRANT;
      gnt_d    = pick_oh;
      gnt_id_d = pick_id;
      ptr_d    = pick_ptr;
      cnt_d    = CNT_ONE;
    end
  end

  assign gnt_vld_d = |gnt_d;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      expire_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      expire_q  <= expire_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_vld = gnt_vld_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.expire  = expire_q;

  // -------------------------------------------------------------------------
  // Structural invariants
  // -------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_q));
  a_vld_matches : assert property (@(posedge clk) disable iff (!rst_n)
    gnt_vld_q == (|gnt_q));
  a_cnt_bound   : assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= CNT_MAX);
`endif

endmodule
